// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// instruction size and the queue entry layout pairing an instruction with its PC.
package if_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [XLEN_DEF-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Memory request/response and decode-side handshake bundle of the fetch queue.
// master is the fetch unit side, slave is the memory/decode environment side.
interface if_fetch_queue_if
    import if_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);
    logic               MemReqValid;
    logic               MemReqReady;
    logic [XLEN-1:0]    MemReqAddr;
    logic               MemRespValid;
    logic [INSTR_W-1:0] MemRespData;
    logic               OutValid;
    logic               OutReady;
    logic [INSTR_W-1:0] Instruction;
    logic [XLEN-1:0]    PCResult;
    logic [XLEN-1:0]    PCAdder_Out;

    modport master (
        output MemReqValid, MemReqAddr,
        input  MemReqReady,
        input  MemRespValid, MemRespData,
        output OutValid, Instruction, PCResult, PCAdder_Out,
        input  OutReady
    );

    modport slave (
        input  MemReqValid, MemReqAddr,
        output MemReqReady,
        output MemRespValid, MemRespData,
        input  OutValid, Instruction, PCResult, PCAdder_Out,
        output OutReady
    );
endinterface

// File: rtl/if_fetch_queue_chk.sv
// Protocol checks for the fetch queue: responses need an outstanding request,
// and the discard counter never exceeds the outstanding count.
module if_fetch_queue_chk #(
    parameter int CW = 3
) (
    input logic          Clock,
    input logic          Reset,
    input logic          resp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop
);
    a_resp_legal: assert property (@(posedge Clock) disable iff (!Reset)
        resp_valid |-> (outstanding != {CW{1'b0}}))
        else $error("fetch response arrived with no request outstanding");

    a_drop_bound: assert property (@(posedge Clock) disable iff (!Reset)
        drop <= outstanding)
        else $error("discard count exceeds outstanding requests");
endmodule

// File: rtl/if_fifo.sv
// DEPTH-entry prefetch FIFO with push, pop, flush and a registered head entry.
// Storage is cleared on reset so the head reads as zero until the first push.
module if_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output T              head
);
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    T              mem_r [DEPTH];
    logic          pop_ok_s;
    logic          push_ok_s;

    // Flush wins over both sides; a full queue accepts a push only alongside a pop.
    assign pop_ok_s  = pop && !flush && (count_r != {CW{1'b0}});
    assign push_ok_s = push && !flush && ((count_r != CW'(DEPTH)) || pop_ok_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC owner, credit-limited request issue, epoch drop
// on redirect, prefetch queue toward decode. IF_STATS_EN adds pop/discard counters.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Redirect,
    input  logic [XLEN-1:0]   RedirectPC,
    if_fetch_queue_if.master  bus
`ifdef IF_STATS_EN
    ,
    output logic [31:0]       StatFetched,
    output logic [31:0]       StatDropped
`endif
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_r;
    logic [CW-1:0]   outstanding_nxt_s;
    logic [CW-1:0]   drop_nxt_s;
    logic [CW-1:0]   count_s;
    logic [CW:0]     credit_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            resp_fire_s;
    logic            drop_hit_s;
    logic            push_s;
    logic            pop_s;
    entry_t          push_entry_s;
    entry_t          head_s;

    // Live in-flight responses plus queued entries must leave a free slot, so a push never overflows.
    assign credit_s    = ({1'b0, outstanding_r} - {1'b0, drop_r}) + {1'b0, count_s};
    assign req_valid_s = Reset && !Redirect && (outstanding_r < CW'(DEPTH))
                         && (credit_s < (CW+1)'(DEPTH));
    assign req_fire_s  = req_valid_s && bus.MemReqReady;
    assign resp_fire_s = bus.MemRespValid && (outstanding_r != {CW{1'b0}});
    assign drop_hit_s  = resp_fire_s && ((drop_r != {CW{1'b0}}) || Redirect);
    assign push_s      = resp_fire_s && !drop_hit_s;
    assign pop_s       = bus.OutValid && bus.OutReady && !Redirect;

    assign push_entry_s = '{instr: bus.MemRespData, pc: resp_pc_r};

    // Outstanding-request count after this cycle's request and response.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        case ({req_fire_s, resp_fire_s})
            2'b10:   outstanding_nxt_s = outstanding_r + CW'(1'b1);
            2'b01:   outstanding_nxt_s = outstanding_r - CW'(1'b1);
            default: outstanding_nxt_s = outstanding_r;
        endcase
    end

    // A redirect marks everything still in flight as stale.
    always_comb begin
        drop_nxt_s = drop_r;
        if (Redirect) begin
            drop_nxt_s = outstanding_nxt_s;
        end else if (resp_fire_s && (drop_r != {CW{1'b0}})) begin
            drop_nxt_s = drop_r - CW'(1'b1);
        end else begin
            drop_nxt_s = drop_r;
        end
    end

    // Fetch/response PCs and request bookkeeping.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
        end else begin
            outstanding_r <= outstanding_nxt_s;
            drop_r        <= drop_nxt_s;
            if (Redirect) begin
                fetch_pc_r <= RedirectPC;
                resp_pc_r  <= RedirectPC;
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + XLEN'(INSTR_BYTES);
                end
                if (push_s) begin
                    resp_pc_r <= resp_pc_r + XLEN'(INSTR_BYTES);
                end
            end
        end
    end

    if_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push_s),
        .din   (push_entry_s),
        .pop   (pop_s),
        .flush (Redirect),
        .count (count_s),
        .head  (head_s)
    );

    assign bus.MemReqValid = req_valid_s;
    assign bus.MemReqAddr  = fetch_pc_r;
    assign bus.OutValid    = (count_s != {CW{1'b0}});
    assign bus.Instruction = head_s.instr;
    assign bus.PCResult    = head_s.pc;
    assign bus.PCAdder_Out = head_s.pc + XLEN'(INSTR_BYTES);

    if_fetch_queue_chk #(
        .CW (CW)
    ) u_chk (
        .Clock       (Clock),
        .Reset       (Reset),
        .resp_valid  (bus.MemRespValid),
        .outstanding (outstanding_r),
        .drop        (drop_r)
    );

`ifdef IF_STATS_EN
    logic [31:0] stat_fetched_r;
    logic [31:0] stat_dropped_r;

    // Discards cover stale responses and entries flushed by a redirect.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stat_fetched_r <= 32'd0;
            stat_dropped_r <= 32'd0;
        end else begin
            stat_fetched_r <= stat_fetched_r + 32'(pop_s);
            stat_dropped_r <= stat_dropped_r + 32'(drop_hit_s)
                              + (Redirect ? 32'(count_s) : 32'd0);
        end
    end

    assign StatFetched = stat_fetched_r;
    assign StatDropped = stat_dropped_r;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order memory model of selectable latency.
module tb_if_fetch_queue;
    import if_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        Redirect;
    logic [31:0] RedirectPC;
`ifdef IF_STATS_EN
    logic [31:0] StatFetched;
    logic [31:0] StatDropped;
`endif

    if_fetch_queue_if #(.XLEN(32), .INSTR_W(32)) bus ();

    if_fetch_queue #(
        .XLEN     (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC),
        .bus         (bus)
`ifdef IF_STATS_EN
        ,
        .StatFetched (StatFetched),
        .StatDropped (StatDropped)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cyc     = 0;
    logic [31:0] req_log [$];
    logic [31:0] pop_log [$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq [$];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic next();
        @(posedge Clock);
        #1;
    endtask

    task automatic sample();
        @(negedge Clock);
        #1;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        Reset           = 1'b0;
        Redirect        = 1'b0;
        RedirectPC      = 32'h0;
        bus.OutReady    = rdy;
        bus.MemReqReady = 1'b1;
        next();
        next();
        lat = l;
        req_log.delete();
        pop_log.delete();
        Reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k;
        k = 0;
        while (!bus.OutValid && k < limit) begin
            next();
            sample();
            k++;
        end
        check_eq(tag, 64'(bus.OutValid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_reqv"}, 64'(bus.MemReqValid), 64'd0);
        check_eq({tag, "_outv"}, 64'(bus.OutValid),    64'd0);
        check_eq({tag, "_instr"}, 64'(bus.Instruction), 64'd0);
        check_eq({tag, "_pc"},   64'(bus.PCResult),    64'd0);
        check_eq({tag, "_pc4"},  64'(bus.PCAdder_Out), 64'd4);
    endtask

    // Memory model and fire logger: samples handshakes at negedge, updates after posedge.
    initial begin
        logic        req_f;
        logic        resp_f;
        logic [31:0] req_a;
        bus.MemRespValid = 1'b0;
        bus.MemRespData  = 32'h0;
        forever begin
            @(negedge Clock);
            req_f  = Reset && bus.MemReqValid && bus.MemReqReady;
            resp_f = Reset && bus.MemRespValid;
            req_a  = bus.MemReqAddr;
            if (req_f) req_log.push_back(req_a);
            if (Reset && bus.OutValid && bus.OutReady && !Redirect) pop_log.push_back(bus.PCResult);
            @(posedge Clock);
            #1;
            cyc++;
            if (!Reset) begin
                mq.delete();
            end else begin
                if (resp_f && mq.size() > 0) void'(mq.pop_front());
                if (req_f) mq.push_back('{req_a, cyc + lat - 1});
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.MemRespValid = 1'b1;
                bus.MemRespData  = instr_of(mq[0].addr);
            end else begin
                bus.MemRespValid = 1'b0;
                bus.MemRespData  = 32'h0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset           = 1'b0;
        Redirect        = 1'b0;
        RedirectPC      = 32'h0;
        bus.MemReqReady = 1'b1;
        bus.OutReady    = 1'b1;

        // Reset state
        sample();
        check_reset_outputs("rst");

        // Streaming, latency 1
        do_reset(1, 1'b1);
        sample();
        check_eq("t1_c0_reqv",  64'(bus.MemReqValid), 64'd1);
        check_eq("t1_c0_addr",  64'(bus.MemReqAddr),  64'h0);
        check_eq("t1_c0_outv",  64'(bus.OutValid),    64'd0);
        next(); sample();
        check_eq("t1_c1_outv",  64'(bus.OutValid),    64'd0);
        next(); sample();
        check_eq("t1_c2_outv",  64'(bus.OutValid),    64'd1);
        check_eq("t1_c2_pc",    64'(bus.PCResult),    64'h0);
        check_eq("t1_c2_pc4",   64'(bus.PCAdder_Out), 64'h4);
        check_eq("t1_c2_instr", 64'(bus.Instruction), 64'(instr_of(32'h0)));
        next(); sample();
        check_eq("t1_c3_pc",    64'(bus.PCResult),    64'h4);
        check_eq("t1_c3_pc4",   64'(bus.PCAdder_Out), 64'h8);
        next(); sample();
        check_eq("t1_c4_pc",    64'(bus.PCResult),    64'h8);
        check_eq("t1_c4_pc4",   64'(bus.PCAdder_Out), 64'hC);
        check_eq("t1_req1",     64'(req_log[1]),      64'h4);
        check_eq("t1_req4",     64'(req_log[4]),      64'h10);

        // Decode backpressure fills the queue, then drains
        do_reset(1, 1'b0);
        sample();
        repeat (10) begin next(); sample(); end
        check_eq("t2_nreq",     64'(req_log.size()),  64'd4);
        check_eq("t2_reqv",     64'(bus.MemReqValid), 64'd0);
        check_eq("t2_outv",     64'(bus.OutValid),    64'd1);
        check_eq("t2_head",     64'(bus.PCResult),    64'h0);
        next(); bus.OutReady = 1'b1; sample();
        check_eq("t2_pop0",     64'(bus.PCResult),    64'h0);
        next(); sample();
        check_eq("t2_pop1",     64'(bus.PCResult),    64'h4);
        next(); sample();
        check_eq("t2_pop2",     64'(bus.PCResult),    64'h8);
        next(); sample();
        check_eq("t2_pop3",     64'(bus.PCResult),    64'hC);
        next(); sample();
        check_eq("t2_resume_v", 64'(bus.OutValid),    64'd1);
        check_eq("t2_resume",   64'(bus.PCResult),    64'h10);
        check_eq("t2_req4",     64'(req_log[4]),      64'h10);

        // Redirect with two stale requests in flight, latency 3
        do_reset(3, 1'b1);
        sample();
        next(); sample();
        next(); Redirect = 1'b1; RedirectPC = 32'h100; sample();
        check_eq("t3_redir_reqv", 64'(bus.MemReqValid), 64'd0);
        next(); Redirect = 1'b0; sample();
        check_eq("t3_empty",    64'(bus.OutValid),    64'd0);
        wait_valid("t3_first_valid", 12);
        check_eq("t3_pc",       64'(bus.PCResult),    64'h100);
        check_eq("t3_instr",    64'(bus.Instruction), 64'(instr_of(32'h100)));
        check_eq("t3_req2",     64'(req_log[2]),      64'h100);

        // Redirect coinciding with a response and a pop, latency 2
        do_reset(2, 1'b1);
        sample();
        repeat (4) begin next(); sample(); end
        next(); Redirect = 1'b1; RedirectPC = 32'h200; sample();
        next(); Redirect = 1'b0; sample();
        check_eq("t4_flushed",  64'(bus.OutValid),      64'd0);
        check_eq("t4_drop",     64'(dut.drop_r),        64'd1);
        check_eq("t4_outst",    64'(dut.outstanding_r), 64'd1);
        check_eq("t4_npop",     64'(pop_log.size()),    64'd2);
        check_eq("t4_reqv",     64'(bus.MemReqValid),   64'd1);
        check_eq("t4_addr",     64'(bus.MemReqAddr),    64'h200);
        wait_valid("t4_first_valid", 12);
        check_eq("t4_pc",       64'(bus.PCResult),      64'h200);

        // Five pops, then a redirect with two queued and one in flight
        do_reset(1, 1'b1);
        sample();
        repeat (6) begin next(); sample(); end
        next(); bus.OutReady = 1'b0; sample();
        next(); Redirect = 1'b1; RedirectPC = 32'h300; sample();
        check_eq("t6_queued_v", 64'(bus.OutValid),    64'd1);
        check_eq("t6_queued",   64'(bus.PCResult),    64'h14);
        next(); Redirect = 1'b0; bus.OutReady = 1'b1; sample();
        check_eq("t6_flushed",  64'(bus.OutValid),    64'd0);
        check_eq("t6_npop",     64'(pop_log.size()),  64'd5);
`ifdef IF_STATS_EN
        check_eq("t6_stat_fetched", 64'(StatFetched), 64'd5);
        check_eq("t6_stat_dropped", 64'(StatDropped), 64'd3);
`endif
        wait_valid("t6_first_valid", 12);
        check_eq("t6_pc",       64'(bus.PCResult),    64'h300);

        // Asynchronous reset with requests outstanding and entries queued
        do_reset(3, 1'b0);
        sample();
        repeat (5) begin next(); sample(); end
        check_eq("t5_pre_outv", 64'(bus.OutValid),    64'd1);
        #1;
        Reset = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        next();
        next();
        req_log.delete();
        pop_log.delete();
        Reset        = 1'b1;
        bus.OutReady = 1'b1;
        sample();
        check_eq("t5_reqv",     64'(bus.MemReqValid), 64'd1);
        check_eq("t5_addr",     64'(bus.MemReqAddr),  64'h0);
        wait_valid("t5_first_valid", 12);
        check_eq("t5_pc",       64'(bus.PCResult),    64'h0);
        check_eq("t5_instr",    64'(bus.Instruction), 64'(instr_of(32'h0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
